// File: rtl/ysyx_041461_id_exe_reg_pkg.sv
// Shared types and NOP encodings for the ID/EXE pipeline register.
// NOP values mirror the core-wide encodings (EXE_NOP, EXE_src_NOP, MEM_NOP, WB_NOP, TRAP_NOP).
package ysyx_041461_id_exe_reg_pkg;

  localparam logic [4:0] EXE_NOP     = 5'd0;
  localparam logic [2:0] EXE_src_NOP = 3'd0;
  localparam logic [3:0] MEM_NOP     = 4'd0;
  localparam logic [3:0] WB_NOP      = 4'd0;
  localparam logic [3:0] TRAP_NOP    = 4'd0;

  // Control fields that get forced to NOP whenever the EXE slot is emptied.
  typedef struct packed {
    logic [4:0] exe_ctrl;
    logic [2:0] exe_src;
    logic [3:0] mem_ctrl;
    logic [3:0] wb_ctrl;
    logic [3:0] trap;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    exe_ctrl: EXE_NOP,
    exe_src:  EXE_src_NOP,
    mem_ctrl: MEM_NOP,
    wb_ctrl:  WB_NOP,
    trap:     TRAP_NOP
  };

  typedef enum logic [1:0] {
    OP_LOAD,
    OP_HOLD,
    OP_BUBBLE,
    OP_FLUSH
  } slot_op_e;

endpackage

// File: rtl/ysyx_041461_id_exe_reg_perf_cnt.sv
// 64-bit free-running event counter with synchronous active-high reset; wraps at 2^64.
module ysyx_041461_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [63:0] count
);

  logic [63:0] count_q;

  always_ff @(posedge clk) begin
    if (rst)     count_q <= 64'd0;
    else if (en) count_q <= count_q + 64'd1;
  end

  assign count = count_q;

endmodule

// File: rtl/ysyx_041461_id_exe_reg.sv
// ID->EXE pipeline register: load, hold, bubble and flush of the decoded bundle.
// Define YSYX_041461_IDEXE_PERF_EN to add the stall/bubble performance counters.
module ysyx_041461_id_exe_reg
  import ysyx_041461_id_exe_reg_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [31:0]     id_inst,
  input  logic [4:0]      id_exe_ctrl,
  input  logic [2:0]      id_exe_src,
  input  logic [3:0]      id_mem_ctrl,
  input  logic [3:0]      id_wb_ctrl,
  input  logic [4:0]      id_rd,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [11:0]     id_csr,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_trap,
  input  logic            cd_id_conflict,
  input  logic            cd_exe_conflict,
  input  logic            cd_exe_trap,
  input  logic            exe_ready,
  output logic            id_ready,
`ifdef YSYX_041461_IDEXE_PERF_EN
  output logic [63:0]     perf_stall_cnt,
  output logic [63:0]     perf_bubble_cnt,
`endif
  output logic            exe_valid,
  output logic [XLEN-1:0] exe_pc,
  output logic [31:0]     exe_inst,
  output logic [4:0]      exe_exe_ctrl,
  output logic [2:0]      exe_exe_src,
  output logic [3:0]      exe_mem_ctrl,
  output logic [3:0]      exe_wb_ctrl,
  output logic [4:0]      exe_rd,
  output logic [4:0]      exe_rs1,
  output logic [4:0]      exe_rs2,
  output logic [11:0]     exe_csr,
  output logic [XLEN-1:0] exe_imm,
  output logic [3:0]      exe_trap
);

  logic            valid_q, valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
  logic [31:0]     inst_q, inst_d;
  logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [11:0]     csr_q, csr_d;

  logic     hold, flush, bubble;
  slot_op_e op;

  // An empty slot never holds, so a bubble is always overwritten.
  assign hold   = valid_q & (cd_exe_conflict | ~exe_ready);
  assign flush  = cd_exe_trap;
  assign bubble = ~id_valid | cd_id_conflict;

  assign id_ready = ~hold & ~cd_id_conflict & ~rst;

  always_comb begin
    op = OP_LOAD;
    if (flush)       op = OP_FLUSH;
    else if (hold)   op = OP_HOLD;
    else if (bubble) op = OP_BUBBLE;
  end

  // NOTE: every next-state signal defaults to its current value first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    csr_d   = csr_q;
    imm_d   = imm_q;
    unique case (op)
      OP_FLUSH, OP_BUBBLE: begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_NOP;
      end
      OP_HOLD: ;
      OP_LOAD: begin
        valid_d = 1'b1;
        ctrl_d  = '{exe_ctrl: id_exe_ctrl, exe_src: id_exe_src, mem_ctrl: id_mem_ctrl,
                    wb_ctrl: id_wb_ctrl, trap: id_trap};
        pc_d    = id_pc;
        inst_d  = id_inst;
        rd_d    = id_rd;
        rs1_d   = id_rs1;
        rs2_d   = id_rs2;
        csr_d   = id_csr;
        imm_d   = id_imm;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
      pc_q    <= '0;
      inst_q  <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      csr_q   <= '0;
      imm_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      csr_q   <= csr_d;
      imm_q   <= imm_d;
    end
  end

  assign exe_valid    = valid_q;
  assign exe_exe_ctrl = ctrl_q.exe_ctrl;
  assign exe_exe_src  = ctrl_q.exe_src;
  assign exe_mem_ctrl = ctrl_q.mem_ctrl;
  assign exe_wb_ctrl  = ctrl_q.wb_ctrl;
  assign exe_trap     = ctrl_q.trap;
  assign exe_pc       = pc_q;
  assign exe_inst     = inst_q;
  assign exe_rd       = rd_q;
  assign exe_rs1      = rs1_q;
  assign exe_rs2      = rs2_q;
  assign exe_csr      = csr_q;
  assign exe_imm      = imm_q;

`ifdef YSYX_041461_IDEXE_PERF_EN
  ysyx_041461_perf_cnt u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (hold & ~flush),
    .count (perf_stall_cnt)
  );

  ysyx_041461_perf_cnt u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    ((op == OP_BUBBLE) & id_valid),
    .count (perf_bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_ysyx_041461_id_exe_reg.sv
// Directed bench for the ID/EXE register with a reference model feeding an expected-state queue.
module tb_ysyx_041461_id_exe_reg;
  import ysyx_041461_id_exe_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst, id_valid;
  logic [63:0] id_pc, id_imm;
  logic [31:0] id_inst;
  logic [4:0]  id_exe_ctrl, id_rd, id_rs1, id_rs2;
  logic [2:0]  id_exe_src;
  logic [3:0]  id_mem_ctrl, id_wb_ctrl, id_trap;
  logic [11:0] id_csr;
  logic        cd_id_conflict, cd_exe_conflict, cd_exe_trap, exe_ready;
  logic        id_ready, exe_valid;
  logic [63:0] exe_pc, exe_imm;
  logic [31:0] exe_inst;
  logic [4:0]  exe_exe_ctrl, exe_rd, exe_rs1, exe_rs2;
  logic [2:0]  exe_exe_src;
  logic [3:0]  exe_mem_ctrl, exe_wb_ctrl, exe_trap;
  logic [11:0] exe_csr;
`ifdef YSYX_041461_IDEXE_PERF_EN
  logic [63:0] perf_stall_cnt, perf_bubble_cnt;
  logic [63:0] m_stall, m_bubble;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_041461_id_exe_reg #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_exe_ctrl(id_exe_ctrl), .id_exe_src(id_exe_src), .id_mem_ctrl(id_mem_ctrl),
    .id_wb_ctrl(id_wb_ctrl), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_csr(id_csr), .id_imm(id_imm), .id_trap(id_trap),
    .cd_id_conflict(cd_id_conflict), .cd_exe_conflict(cd_exe_conflict),
    .cd_exe_trap(cd_exe_trap), .exe_ready(exe_ready), .id_ready(id_ready),
`ifdef YSYX_041461_IDEXE_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
    .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_inst(exe_inst),
    .exe_exe_ctrl(exe_exe_ctrl), .exe_exe_src(exe_exe_src), .exe_mem_ctrl(exe_mem_ctrl),
    .exe_wb_ctrl(exe_wb_ctrl), .exe_rd(exe_rd), .exe_rs1(exe_rs1), .exe_rs2(exe_rs2),
    .exe_csr(exe_csr), .exe_imm(exe_imm), .exe_trap(exe_trap)
  );

  typedef struct {
    logic        valid;
    logic [63:0] pc, imm;
    logic [31:0] inst;
    logic [4:0]  ectl, rd, rs1, rs2;
    logic [2:0]  esrc;
    logic [3:0]  mctl, wctl, trap;
    logic [11:0] csr;
  } snap_t;

  snap_t m;
  snap_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_nop();
    m.valid = 1'b0;
    m.ectl  = EXE_NOP;
    m.esrc  = EXE_src_NOP;
    m.mctl  = MEM_NOP;
    m.wctl  = WB_NOP;
    m.trap  = TRAP_NOP;
  endtask

  task automatic new_payload(input logic [63:0] pc);
    id_pc       = pc;
    id_inst     = $urandom;
    id_exe_ctrl = 5'($urandom_range(31, 1));
    id_exe_src  = 3'($urandom_range(7, 1));
    id_mem_ctrl = 4'($urandom_range(15, 1));
    id_wb_ctrl  = 4'($urandom_range(15, 1));
    id_rd       = 5'($urandom);
    id_rs1      = 5'($urandom);
    id_rs2      = 5'($urandom);
    id_csr      = 12'($urandom);
    id_imm      = {$urandom, $urandom};
    id_trap     = 4'd0;
  endtask

  // One clock: model predicts, id_ready is checked, expected state is queued then compared after the edge.
  task automatic step();
    logic  hold, exp_ready;
    snap_t e;
    #1;
    hold      = m.valid & (cd_exe_conflict | ~exe_ready);
    exp_ready = ~hold & ~cd_id_conflict & ~rst;
    check("id_ready", 64'(id_ready), 64'(exp_ready));
`ifdef YSYX_041461_IDEXE_PERF_EN
    if (rst) begin
      m_stall = 0; m_bubble = 0;
    end else begin
      if (hold & ~cd_exe_trap) m_stall++;
      if (~cd_exe_trap & ~hold & (~id_valid | cd_id_conflict) & id_valid) m_bubble++;
    end
`endif
    if (rst) begin
      model_nop();
      m.pc = '0; m.imm = '0; m.inst = '0; m.rd = '0; m.rs1 = '0; m.rs2 = '0; m.csr = '0;
    end else if (cd_exe_trap) begin
      model_nop();
    end else if (hold) begin
      // slot keeps its contents
    end else if (~id_valid | cd_id_conflict) begin
      model_nop();
    end else begin
      m.valid = 1'b1; m.pc = id_pc; m.inst = id_inst; m.ectl = id_exe_ctrl;
      m.esrc = id_exe_src; m.mctl = id_mem_ctrl; m.wctl = id_wb_ctrl; m.rd = id_rd;
      m.rs1 = id_rs1; m.rs2 = id_rs2; m.csr = id_csr; m.imm = id_imm; m.trap = id_trap;
    end
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("exe_valid", 64'(exe_valid), 64'(e.valid));
    check("exe_pc", exe_pc, e.pc);
    check("exe_inst", 64'(exe_inst), 64'(e.inst));
    check("exe_exe_ctrl", 64'(exe_exe_ctrl), 64'(e.ectl));
    check("exe_exe_src", 64'(exe_exe_src), 64'(e.esrc));
    check("exe_mem_ctrl", 64'(exe_mem_ctrl), 64'(e.mctl));
    check("exe_wb_ctrl", 64'(exe_wb_ctrl), 64'(e.wctl));
    check("exe_rd", 64'(exe_rd), 64'(e.rd));
    check("exe_rs1", 64'(exe_rs1), 64'(e.rs1));
    check("exe_rs2", 64'(exe_rs2), 64'(e.rs2));
    check("exe_csr", 64'(exe_csr), 64'(e.csr));
    check("exe_imm", exe_imm, e.imm);
    check("exe_trap", 64'(exe_trap), 64'(e.trap));
`ifdef YSYX_041461_IDEXE_PERF_EN
    check("perf_stall_cnt", perf_stall_cnt, m_stall);
    check("perf_bubble_cnt", perf_bubble_cnt, m_bubble);
`endif
  endtask

  initial begin
    logic [63:0] held_pc, held_imm;
    m = '{default: '0};
`ifdef YSYX_041461_IDEXE_PERF_EN
    m_stall = 0; m_bubble = 0;
`endif
    @(posedge clk);
    #1;

    // Reset with a live ID instruction
    rst = 1; id_valid = 1; cd_id_conflict = 0; cd_exe_conflict = 0; cd_exe_trap = 0;
    exe_ready = 1;
    new_payload(64'h1234_5678_9abc_def0);
    step(); step();
    check("rst_valid", 64'(exe_valid), 64'd0);
    check("rst_wb", 64'(exe_wb_ctrl), 64'(WB_NOP));
    check("rst_pc", exe_pc, 64'd0);

    // Straight flow
    rst = 0;
    new_payload(64'h8000_0000);
    id_rd = 5'd5;
    step();
    check("flow_valid", 64'(exe_valid), 64'd1);
    check("flow_pc", exe_pc, 64'h8000_0000);
    check("flow_rd", 64'(exe_rd), 64'd5);

    // ID hazard for two cycles, then release
    new_payload(64'h8000_0004);
    cd_id_conflict = 1;
    step();
    check("idhz_valid", 64'(exe_valid), 64'd0);
    check("idhz_ctrl", 64'(exe_exe_ctrl), 64'(EXE_NOP));
    step();
    check("idhz_valid2", 64'(exe_valid), 64'd0);
    cd_id_conflict = 0;
    step();
    check("idhz_release_pc", exe_pc, 64'h8000_0004);

    // EXE busy with a live slot: payload must stay put for three cycles
    held_pc  = exe_pc;
    held_imm = exe_imm;
    exe_ready = 0;
    for (int i = 0; i < 3; i++) begin
      new_payload(64'h8000_0100 + 64'(i * 4));
      step();
    end
    check("busy_pc", exe_pc, held_pc);
    check("busy_imm", exe_imm, held_imm);

    // Bubble in EXE never holds, even with exe_ready low and an EXE conflict
    exe_ready = 1; id_valid = 0;
    step();
    exe_ready = 0; cd_exe_conflict = 1; id_valid = 1;
    new_payload(64'h8000_0200);
    step();
    check("bubble_overwrite_valid", 64'(exe_valid), 64'd1);
    check("bubble_overwrite_pc", exe_pc, 64'h8000_0200);

    // Flush beats hold in the same cycle
    cd_exe_trap = 1;
    new_payload(64'h8000_0300);
    id_trap = 4'h7;
    step();
    check("flush_valid", 64'(exe_valid), 64'd0);
    check("flush_trap", 64'(exe_trap), 64'(TRAP_NOP));
    cd_exe_trap = 0; cd_exe_conflict = 0; exe_ready = 1;

    // Trap code forwarded unchanged on a normal load
    new_payload(64'h8000_0400);
    id_trap = 4'h3;
    step();
    check("trap_fwd", 64'(exe_trap), 64'h3);

    // Reset during a hold empties the slot
    exe_ready = 0; rst = 1;
    step();
    check("rst_hold_valid", 64'(exe_valid), 64'd0);
    rst = 0; exe_ready = 1;

    // Three hold cycles then two ID-hazard bubbles from a fresh reset
    rst = 1; step(); rst = 0;
    new_payload(64'h8000_0500);
    step();
    exe_ready = 0;
    step(); step(); step();
    exe_ready = 1; cd_id_conflict = 1;
    step(); step();
    cd_id_conflict = 0;
`ifdef YSYX_041461_IDEXE_PERF_EN
    check("perf_stall_3", perf_stall_cnt, 64'd3);
    check("perf_bubble_2", perf_bubble_cnt, 64'd2);
`endif

    // Mixed random traffic
    for (int i = 0; i < 40; i++) begin
      new_payload({$urandom, $urandom});
      id_trap         = 4'($urandom_range(3));
      id_valid        = 1'($urandom_range(3) != 0);
      cd_id_conflict  = 1'($urandom_range(3) == 0);
      cd_exe_conflict = 1'($urandom_range(3) == 0);
      cd_exe_trap     = 1'($urandom_range(7) == 0);
      exe_ready       = 1'($urandom_range(3) != 0);
      rst             = 1'($urandom_range(19) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
